// File: rtl/output_deskew_buffer.sv
// Purpose : removes the one-cycle-per-column skew at the array bottom edge and queues complete rows.
// Latency : a row is written on the edge that samples lane ARRAYWIDTH-1; out_valid rises right after that edge.
// Backpr. : the array cannot stall. Rows that arrive while the FIFO is full are dropped and set overflow.
//
// Ports:
//   clk, rst (async, active-low), flush (sync clear of lines, FIFO and flags)
//   in_valid/in_data   : skewed per-lane results; lane j is in bits [(j+1)*DATASIZE-1 : j*DATASIZE]
//   out_valid/out_ready/out_data : deskewed row handshake; a pop happens on out_valid && out_ready
//   fifo_count         : number of stored rows, including the row shown on out_data
//   overflow, skew_err : sticky fault flags
module output_deskew_buffer #(
  parameter int ARRAYWIDTH = 4,
  parameter int DATASIZE   = 16,
  parameter int DEPTH      = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [ARRAYWIDTH-1:0]          in_valid,
  input  logic [ARRAYWIDTH*DATASIZE-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ARRAYWIDTH*DATASIZE-1:0] out_data,
  output logic [$clog2(DEPTH):0]         fifo_count,
  output logic                           overflow,
  output logic                           skew_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = ARRAYWIDTH * DATASIZE;

  logic [ARRAYWIDTH-1:0] w_av;
  logic [RW-1:0]         w_row;

  // Lane j is delayed by ARRAYWIDTH-1-j cycles, so every lane of a row lines up
  // with the last lane, which passes straight through.
  for (genvar gj = 0; gj < ARRAYWIDTH; gj++) begin : g_lane
    localparam int D = ARRAYWIDTH - 1 - gj;
    if (D == 0) begin : g_pass
      assign w_av[gj]                       = in_valid[gj];
      assign w_row[gj*DATASIZE +: DATASIZE] = in_data[gj*DATASIZE +: DATASIZE];
    end else begin : g_dly
      logic [D-1:0]               r_vld;
      logic [D-1:0][DATASIZE-1:0] r_dat;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_vld <= '0;
          r_dat <= '0;
        end else begin
          // Flush kills every valid bit, including the one being sampled now.
          r_vld[0] <= in_valid[gj] & ~flush;
          r_dat[0] <= in_data[gj*DATASIZE +: DATASIZE];
          for (int k = 1; k < D; k++) begin
            r_vld[k] <= r_vld[k-1] & ~flush;
            r_dat[k] <= r_dat[k-1];
          end
        end
      end

      assign w_av[gj]                       = r_vld[D-1];
      assign w_row[gj*DATASIZE +: DATASIZE] = r_dat[D-1];
    end
  end

  logic [RW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          r_out_vld;
  logic [RW-1:0] r_out_dat;
  logic          r_ovf;
  logic          r_skew;

  logic          w_full;
  logic          w_pop;
  logic          w_row_full;
  logic          w_push;
  logic          w_ovf;
  logic          w_skew;
  logic [AW:0]   w_wptr_nxt;
  logic [AW:0]   w_rptr_nxt;
  logic [RW-1:0] w_head;

  assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop      = r_out_vld & out_ready;
  assign w_row_full = &w_av;
  // A simultaneous pop frees the slot, so a full FIFO can still accept the row.
  assign w_push     = w_row_full & (~w_full | w_pop);
  assign w_ovf      = w_row_full & w_full & ~w_pop;
  assign w_skew     = (|w_av) & ~w_row_full;
  assign w_wptr_nxt = r_wptr + {{AW{1'b0}}, w_push};
  assign w_rptr_nxt = r_rptr + {{AW{1'b0}}, w_pop};

  // The next head is the row being written this edge when it lands in the next
  // read slot. This happens only when the FIFO drains to that single row.
  assign w_head = (w_push && (w_rptr_nxt[AW-1:0] == r_wptr[AW-1:0]))
                  ? w_row : r_mem[w_rptr_nxt[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[r_wptr[AW-1:0]] <= w_row;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
      r_ovf     <= 1'b0;
      r_skew    <= 1'b0;
    end else if (flush) begin
      // out_data keeps its last value. Only the valid and state bits clear.
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_out_vld <= 1'b0;
      r_ovf     <= 1'b0;
      r_skew    <= 1'b0;
    end else begin
      r_wptr    <= w_wptr_nxt;
      r_rptr    <= w_rptr_nxt;
      r_out_vld <= (w_wptr_nxt != w_rptr_nxt);
      if (w_wptr_nxt != w_rptr_nxt) begin
        r_out_dat <= w_head;
      end
      if (w_ovf) begin
        r_ovf <= 1'b1;
      end
      if (w_skew) begin
        r_skew <= 1'b1;
      end
    end
  end

  assign out_valid  = r_out_vld;
  assign out_data   = r_out_dat;
  assign fifo_count = r_wptr - r_rptr;
  assign overflow   = r_ovf;
  assign skew_err   = r_skew;

endmodule

// File: tb/tb_output_deskew_buffer.sv
// Purpose : randomized and directed stimulus for output_deskew_buffer, checked against a queue model.
// Latency : the model assumes a row is written on its last-lane edge and is visible right after that edge.
// Backpr. : out_ready is driven per cycle. The model pops only when its queue is non-empty and ready is high.
module tb_output_deskew_buffer;
  localparam int AWD = 4;
  localparam int DS  = 8;
  localparam int DEP = 8;
  localparam int RW  = AWD * DS;
  localparam int CW  = $clog2(DEP) + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic [AWD-1:0] in_valid;
  logic [RW-1:0]  in_data;
  logic           out_valid;
  logic           out_ready;
  logic [RW-1:0]  out_data;
  logic [CW-1:0]  fifo_count;
  logic           overflow;
  logic           skew_err;

  always #5 clk = ~clk;

  output_deskew_buffer #(.ARRAYWIDTH(AWD), .DATASIZE(DS), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fifo_count(fifo_count), .overflow(overflow), .skew_err(skew_err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: a row is the diagonal of the last AWD input cycles.
  // Lane j of the row comes from the input AWD-1-j cycles back.
  logic [RW-1:0]  mq[$];
  bit             m_ovf, m_skew;
  logic [RW-1:0]  m_last;
  logic [AWD-1:0] hv[$];
  logic [RW-1:0]  hd[$];

  task automatic model_reset();
    mq.delete(); hv.delete(); hd.delete();
    m_ovf = 0; m_skew = 0; m_last = '0;
    for (int i = 0; i < AWD-1; i++) begin
      hv.push_back('0);
      hd.push_back('0);
    end
  endtask

  task automatic model_edge();
    logic [AWD-1:0] av;
    logic [RW-1:0]  row;
    bit             pop;
    hv.push_back(in_valid);
    hd.push_back(in_data);
    for (int j = 0; j < AWD; j++) begin
      av[j] = hv[j][j];
      row[j*DS +: DS] = hd[j][j*DS +: DS];
    end
    void'(hv.pop_front());
    void'(hd.pop_front());
    if (flush) begin
      mq.delete();
      m_ovf = 0; m_skew = 0;
      foreach (hv[i]) hv[i] = '0;
    end else begin
      pop = (mq.size() != 0) && out_ready;
      if (&av) begin
        if (mq.size() == DEP && !pop) m_ovf = 1;
        else mq.push_back(row);
      end else if (av != '0) begin
        m_skew = 1;
      end
      if (pop) void'(mq.pop_front());
    end
    if (mq.size() != 0) m_last = mq[0];
  endtask

  task automatic compare_all();
    check("out_valid",  out_valid,  mq.size() != 0);
    check("fifo_count", fifo_count, mq.size());
    check("overflow",   overflow,   m_ovf);
    check("skew_err",   skew_err,   m_skew);
    check("out_data",   out_data,   m_last);
  endtask

  // Per-cycle stimulus schedule: add_row spreads one row over AWD cycles.
  logic [AWD-1:0] sv[32];
  logic [RW-1:0]  sd[32];
  int             cyc = 0;

  task automatic clear_sched();
    for (int i = 0; i < 32; i++) begin
      sv[i] = '0;
      sd[i] = '0;
    end
  endtask

  task automatic add_row(input int off, input logic [RW-1:0] data, input logic [AWD-1:0] mask);
    int slot;
    for (int j = 0; j < AWD; j++) begin
      if (mask[j]) begin
        slot = (cyc + off + j) % 32;
        sv[slot][j] = 1'b1;
        sd[slot][j*DS +: DS] = data[j*DS +: DS];
      end
    end
  endtask

  function automatic logic [RW-1:0] row_of(input int base);
    logic [RW-1:0] r;
    for (int j = 0; j < AWD; j++) r[j*DS +: DS] = DS'(base + j);
    return r;
  endfunction

  task automatic step(input bit f, input bit r);
    int slot;
    slot = cyc % 32;
    in_valid = sv[slot];
    in_data  = sd[slot];
    for (int j = 0; j < AWD; j++)
      if (!sv[slot][j]) in_data[j*DS +: DS] = DS'($urandom);
    flush     = f;
    out_ready = r;
    sv[slot]  = '0;
    sd[slot]  = '0;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    cyc++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vld"}, out_valid,  1'b0);
    check({tag, "_dat"}, out_data,   '0);
    check({tag, "_cnt"}, fifo_count, '0);
    check({tag, "_ovf"}, overflow,   1'b0);
    check({tag, "_skw"}, skew_err,   1'b0);
  endtask

  initial begin
    clear_sched();
    rst = 1'b0; flush = 1'b0; out_ready = 1'b0; in_valid = '0; in_data = '0;
    #12;
    check_all_zero("reset");
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // Single row: write on the 4th edge, pop on the 5th.
    add_row(0, row_of(16), 4'hF);
    repeat (4) step(0, 1);
    check("t1_vld", out_valid, 1'b1);
    check("t1_dat", out_data, 32'h13121110);
    step(0, 1);
    check("t1_cnt", fifo_count, 0);

    // Streaming six back-to-back rows.
    for (int r = 0; r < 6; r++) add_row(r, row_of(r * 16), 4'hF);
    repeat (12) step(0, 1);

    // Backpressure: nine rows into eight slots.
    for (int r = 0; r < 9; r++) add_row(r, row_of(r * 16 + 5), 4'hF);
    repeat (12) step(0, 0);
    check("t3_cnt", fifo_count, 8);
    check("t3_ovf", overflow, 1'b1);
    repeat (10) step(0, 1);

    // Full FIFO with a push and a pop on the same edge.
    step(1, 0);
    for (int r = 0; r < 9; r++) add_row(r, row_of(r * 16 + 9), 4'hF);
    repeat (11) step(0, 0);
    check("t4_full", fifo_count, 8);
    step(0, 1);
    check("t4_cnt", fifo_count, 8);
    check("t4_ovf", overflow, 1'b0);
    repeat (10) step(0, 1);

    // Skew fault: lane 3 missing.
    add_row(0, row_of(200), 4'b0111);
    repeat (5) step(0, 1);
    check("t5_skew", skew_err, 1'b1);
    check("t5_cnt", fifo_count, 0);

    // Flush with three rows stored and one row half inside the delay lines.
    for (int r = 0; r < 3; r++) add_row(r, row_of(r * 16 + 3), 4'hF);
    repeat (6) step(0, 0);
    add_row(0, row_of(99), 4'hF);
    step(0, 0);
    step(0, 0);
    step(1, 0);
    clear_sched();
    check("t6_cnt", fifo_count, 0);
    check("t6_vld", out_valid, 1'b0);
    check("t6_ovf", overflow, 1'b0);
    check("t6_skw", skew_err, 1'b0);
    repeat (8) step(0, 1);

    // Random traffic with occasional faults and flushes.
    for (int i = 0; i < 1600; i++) begin
      if ($urandom_range(2) == 0)
        add_row(0, RW'($urandom), ($urandom_range(9) == 0) ? AWD'($urandom) : 4'hF);
      step($urandom_range(199) == 0,
           (i < 800) ? ($urandom_range(9) < 3) : ($urandom_range(9) < 8));
    end

    // Asynchronous reset between edges with traffic in flight.
    for (int r = 0; r < 4; r++) add_row(r, row_of(r * 16 + 7), 4'hF);
    repeat (6) step(0, 0);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("arst");
    @(posedge clk);
    #1;
    check_all_zero("arst_hold");
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    clear_sched();
    add_row(0, row_of(48), 4'hF);
    repeat (8) step(0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
